// File: rtl/systolic_pkg.sv
// ============================================================================
// Module  : systolic_pkg
// Brief   : Shared state encoding, default array dimensions and width helpers
//           for the systolic array sequencer, PE grid and operand buffers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

    localparam int N_DEF      = 4;
    localparam int K_MAX_DEF  = 256;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ctrl_state_e;

    // Width able to hold any K in 0..K_MAX
    function automatic int klen_w(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    function automatic int addr_w(input int k_max);
        return (k_max > 1) ? $clog2(k_max) : 1;
    endfunction

    // Step counter must reach K_MAX + RD_LAT + 2N - 3 without wrapping
    function automatic int step_w(input int k_max, input int rd_lat, input int n);
        return $clog2(k_max + rd_lat + 2 * n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_ctrl_if.sv
// ============================================================================
// Module  : systolic_ctrl_if
// Brief   : Control/status bundle between the FFN layer control (master) and
//           the systolic sequencer (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_ctrl_if
    import systolic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int K_MAX = K_MAX_DEF
);
    localparam int KW = klen_w(K_MAX);
    localparam int AW = addr_w(K_MAX);

    logic            start_i;
    logic [KW-1:0]   k_len_i;
    logic            ack_i;
    logic            busy_o;
    logic            clr_o;
    logic            rd_en_o;
    logic [AW-1:0]   rd_addr_o;
    logic [N*N-1:0]  acc_en_o;
    logic            done_o;
    logic [31:0]     perf_cycles_o;

    modport master (
        output start_i, k_len_i, ack_i,
        input  busy_o, clr_o, rd_en_o, rd_addr_o, acc_en_o, done_o, perf_cycles_o
    );

    modport slave (
        input  start_i, k_len_i, ack_i,
        output busy_o, clr_o, rd_en_o, rd_addr_o, acc_en_o, done_o, perf_cycles_o
    );

endinterface

`default_nettype wire

// File: rtl/systolic_acc_en_gen.sv
// ============================================================================
// Module  : systolic_acc_en_gen
// Brief   : Combinational per-PE accumulate window: PE(i,j) is enabled while
//           0 <= t - RD_LAT - i - j <= K-1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_acc_en_gen
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int TW     = step_w(K_MAX_DEF, RD_LAT_DEF, N_DEF),
    parameter int KW     = klen_w(K_MAX_DEF)
)(
    input  wire logic [TW-1:0]  i_t,
    input  wire logic [KW-1:0]  i_k,
    input  wire logic           i_active,
    output logic [N*N-1:0]      o_acc_en
);

    // One spare bit so neither the offset nor K can alias the compare
    localparam int EW = ((TW > KW) ? TW : KW) + 1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            for (genvar gj = 0; gj < N; gj++) begin : g_col
                localparam logic [EW-1:0] c_ofs = EW'(RD_LAT + gi + gj);
                logic [EW-1:0] w_t_ext;
                logic [EW-1:0] w_rel;

                assign w_t_ext = EW'(i_t);
                assign w_rel   = w_t_ext - c_ofs;
                assign o_acc_en[gi*N + gj] = i_active
                                           && (w_t_ext >= c_ofs)
                                           && (w_rel < EW'(i_k));
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/systolic_ctrl.sv
// ============================================================================
// Module  : systolic_ctrl
// Brief   : Sequencer for an N x N output-stationary systolic MAC array:
//           clear, K operand reads, skewed accumulate enables, drain, done.
//           Optional busy-cycle counter enabled by SYSTOLIC_CTRL_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int K_MAX  = K_MAX_DEF,
    parameter int RD_LAT = RD_LAT_DEF
)(
    input  wire logic       clk,
    input  wire logic       rst,
    systolic_ctrl_if.slave  bus
);

    localparam int KW        = klen_w(K_MAX);
    localparam int AW        = addr_w(K_MAX);
    localparam int TW        = step_w(K_MAX, RD_LAT, N);
    localparam int DRAIN_LEN = RD_LAT + 2 * (N - 1);

    ctrl_state_e      r_state;
    logic [KW-1:0]    r_k;
    logic [TW-1:0]    r_t;
    logic             r_busy;
    logic             r_clr;
    logic             r_rd_en;
    logic [AW-1:0]    r_rd_addr;
    logic             r_done;

    logic [KW-1:0]    w_k_clamp;
    logic [TW-1:0]    w_t_inc;
    logic             w_feed_last;
    logic             w_drain_last;
    logic             w_active;
    logic [N*N-1:0]   w_acc_en;

    assign w_k_clamp    = (bus.k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len_i;
    assign w_t_inc      = r_t + TW'(1);
    assign w_feed_last  = ((32'(r_t) + 32'd1) == 32'(r_k));
    assign w_drain_last = (32'(r_t) == (32'(r_k) + 32'(RD_LAT + 2 * N - 3)));
    assign w_active     = (r_state == FEED) || (r_state == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_t       <= '0;
            r_busy    <= 1'b0;
            r_clr     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_state <= CLEAR;
                        r_k     <= w_k_clamp;
                        r_busy  <= 1'b1;
                        r_clr   <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_clr <= 1'b0;
                    r_t   <= '0;
                    if (r_k == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= FEED;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                    end
                end
                FEED: begin
                    r_t <= w_t_inc;
                    if (w_feed_last) begin
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= '0;
                        if (DRAIN_LEN == 0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else begin
                        r_rd_addr <= w_t_inc[AW-1:0];
                    end
                end
                DRAIN: begin
                    r_t <= w_t_inc;
                    if (w_drain_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    // A start coinciding with ack is dropped: IDLE samples it next cycle
                    if (bus.ack_i) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_t     <= '0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_clr     <= 1'b0;
                    r_rd_en   <= 1'b0;
                    r_rd_addr <= '0;
                    r_done    <= 1'b0;
                    r_t       <= '0;
                end
            endcase
        end
    end

    systolic_acc_en_gen #(
        .N      (N),
        .RD_LAT (RD_LAT),
        .TW     (TW),
        .KW     (KW)
    ) u_acc_en_gen (
        .i_t      (r_t),
        .i_k      (r_k),
        .i_active (w_active),
        .o_acc_en (w_acc_en)
    );

    assign bus.busy_o    = r_busy;
    assign bus.clr_o     = r_clr;
    assign bus.rd_en_o   = r_rd_en;
    assign bus.rd_addr_o = r_rd_addr;
    assign bus.acc_en_o  = w_acc_en;
    assign bus.done_o    = r_done;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] r_perf_cnt;
    logic [31:0] r_perf_out;
    logic [31:0] w_perf_inc;

    assign w_perf_inc = (&r_perf_cnt) ? r_perf_cnt : (r_perf_cnt + 32'd1);

    // The closing DONE cycle is still busy, so the published value includes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cnt <= '0;
            r_perf_out <= '0;
        end else begin
            if ((r_state == IDLE) && bus.start_i) begin
                r_perf_cnt <= '0;
            end else if (r_busy) begin
                r_perf_cnt <= w_perf_inc;
            end
            if ((r_state == DONE) && bus.ack_i) begin
                r_perf_out <= w_perf_inc;
            end
        end
    end

    assign bus.perf_cycles_o = r_perf_out;
`else
    assign bus.perf_cycles_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for an N x N output-stationary systolic array of signed MAC processing elements (PEs).
- On start: clears all PE accumulators, then issues K operand-buffer reads.
- Generates per-PE accumulate enables that match the diagonal skew of operands moving through the array.
- Waits for the last PE to finish, then holds done until acknowledged.
- Sits between the top-level FFN layer control and the PE grid plus its A/B operand buffers.

Parameters:
N, 4, array dimension (N x N PEs, N A-rows, N B-columns)
K_MAX, 256, maximum inner dimension (accumulation length)
RD_LAT, 1, operand buffer read latency in cycles

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start_i  in  1  begin one matrix tile; sampled only in IDLE
k_len_i  in  $clog2(K_MAX+1)  inner dimension K; sampled with start_i
ack_i  in  1  consumer has read PE results; releases DONE
busy_o  out  1  high in any state other than IDLE
clr_o  out  1  one-cycle synchronous accumulator clear to all PEs
rd_en_o  out  1  operand buffer read enable (A rows and B columns read in parallel)
rd_addr_o  out  $clog2(K_MAX)  operand buffer read address k
acc_en_o  out  N*N  per-PE accumulate enable; bit i*N+j is PE(row i, col j)
done_o  out  1  results stable in all PEs; level until ack_i
perf_cycles_o  out  32  cycles spent busy on the last tile (see optional feature)

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; counters 0. Asserting rst mid-tile aborts immediately; no done_o is produced.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE: on start_i=1, latch K = min(k_len_i, K_MAX) and go to CLEAR.
- CLEAR: exactly 1 cycle with clr_o=1. If K==0, go to DONE (results are zero). Otherwise go to FEED and set t=0.
- Step counter t: increments by 1 each cycle in FEED and DRAIN.
- FEED: lasts K cycles (t = 0..K-1). rd_en_o=1 and rd_addr_o=t.
- DRAIN: lasts RD_LAT + 2(N-1) cycles. It ends when t reaches K+RD_LAT+2N-3, then the block goes to DONE. rd_en_o=0 and rd_addr_o holds 0.
- Skew model: operand k reaches PE(i,j) at t = k + RD_LAT + i + j.
- acc_en bit (i,j) = 1 when the state is FEED or DRAIN and 0 <= t-RD_LAT-i-j <= K-1. This is combinational from the registered t and state. Each PE sees exactly K enable cycles.
- DONE: done_o=1 and busy_o=1 until ack_i=1, then go to IDLE (1-cycle transition). If ack_i is already high on entry, the block stays in DONE for exactly 1 cycle.
- start_i is ignored outside IDLE. No queuing.
- A start_i pulse on the same cycle as ack_i in DONE is ignored. A new start is accepted only from IDLE, the cycle after.
- k_len_i > K_MAX is clamped to K_MAX with no error flag.
- Arithmetic: t width is $clog2(K_MAX+RD_LAT+2N). Window compares use unsigned math with no wrap; t-RD_LAT-i-j < 0 means the bit is disabled.

Optional Feature:
SYSTOLIC_CTRL_PERF_EN
- Defined: a 32-bit counter clears on accepting start_i and increments every cycle busy_o=1. On the DONE->IDLE transition it is copied to perf_cycles_o, which holds until the next tile completes. The counter saturates at 2^32-1. Reset value is 0.
- Undefined: no counter logic; perf_cycles_o is tied to 0.

Decomposition:
- Package systolic_pkg holds:
  - state enum ctrl_state_e {IDLE, CLEAR, FEED, DRAIN, DONE};
  - localparam function clog2-based width helpers;
  - default N, K_MAX and RD_LAT constants, shared with the PE grid and buffers.
- One sub-module: systolic_acc_en_gen (parameters N and RD_LAT; inputs t, K, active; output N*N window enables). It is purely combinational and instantiated once.

Test Plan:
- N=4, RD_LAT=1, K=3, start at cycle 0: clr_o high cycle 1; rd_addr 0,1,2 on cycles 2-4; acc_en[0][0] high for t=1..3; acc_en[3][3] high for t=7..9; done_o rises on cycle 12.
- K=0: CLEAR for 1 cycle, then straight to DONE; acc_en_o and rd_en_o are never asserted.
- k_len_i=300 with K_MAX=256: rd_addr sweeps 0..255 once; each PE sees exactly 256 acc_en cycles (checked by counter per PE).
- start_i held high through a whole tile plus ack_i: exactly one tile runs; IDLE is seen for 1 cycle before the next tile begins.
- rst asserted in the middle of FEED (t=5): all outputs 0 that same cycle (async); after deassert, state is IDLE and done_o never pulses.
- With SYSTOLIC_CTRL_PERF_EN defined, N=4, K=3, ack 2 cycles after done: perf_cycles_o = 1+3+7+3 = 14 after the return to IDLE. Without the macro it reads 0.
